// File: rtl/proc16_pkg.sv
// Shared proc16 definitions: datapath widths, NOP encoding and the fetch-queue entry layout.
package proc16_pkg;

  localparam int unsigned P16_ADDR_W  = 10;
  localparam int unsigned P16_INSTR_W = 16;

  localparam logic [P16_INSTR_W-1:0] P16_NOP = '0;

  typedef struct packed {
    logic [P16_ADDR_W-1:0]  pc;
    logic [P16_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched instructions: wrapping pointers, separate occupancy counter,
// flush, and push+pop when full.
module fetch_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  always_comb begin
    full  = (r_count == (PW+1)'(DEPTH));
    empty = (r_count == '0);
    w_rd  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    w_wr  = push & (~full | w_rd);
    rdata = r_mem[r_rptr];
    count = r_count;
  end

  always_ff @(posedge clk) begin
    if (reset | flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !reset && !flush) r_mem[r_wptr] <= wdata;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    r_count <= (PW+1)'(DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset || flush)
    !(push && full && !pop));

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch prefetch queue: credit-based issue to a 1-cycle instruction memory, PC-tagged
// FIFO to decode, branch flush. Define FETCH_BYPASS_EN to forward returning data when the FIFO is empty.
module fetch_prefetch_queue
  import proc16_pkg::*;
#(
  parameter int unsigned ADDR_W  = P16_ADDR_W,
  parameter int unsigned INSTR_W = P16_INSTR_W,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_addr,
  input  logic               branch,
  output logic               pc_stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  input  logic               id_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = ADDR_W + INSTR_W;

  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;

  logic [EW-1:0]     w_head;
  logic [EW-1:0]     w_resp;
  logic [CW-1:0]     w_count;
  logic [CW:0]       w_used;
  logic              w_full;
  logic              w_empty;
  logic              w_resp_ok;
  logic              w_bypass;
  logic              w_xfer;
  logic              w_push;
  logic              w_pop;
  logic              w_credit;

  always_comb begin
    w_resp    = {r_inflight_pc, imem_rdata};
    // A branch in this cycle kills the response returning now.
    w_resp_ok = r_inflight & ~branch & ~reset;
`ifdef FETCH_BYPASS_EN
    w_bypass  = w_empty & w_resp_ok;
`else
    w_bypass  = 1'b0;
`endif
    id_valid  = ~reset & (~w_empty | w_bypass);
    {id_pc, id_instr} = '0;
    if (id_valid) {id_pc, id_instr} = w_bypass ? w_resp : w_head;
    w_xfer    = id_valid & id_ready;
    w_pop     = w_xfer & ~w_empty;
    w_push    = w_resp_ok & ~(w_bypass & id_ready);
    w_used    = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    w_credit  = w_used < (CW+1)'(DEPTH);
    imem_req  = ~reset & ~branch & (w_credit | w_xfer);
    pc_stall  = ~imem_req;
    imem_addr = pc_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight    <= imem_req;
      r_inflight_pc <= pc_addr;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (branch),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_resp),
    .rdata (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: directed scenarios push expected {pc, instr} entries,
// a monitor pops and compares on every decode-side transfer.
module tb_fetch_prefetch_queue;
  import proc16_pkg::*;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        reset;
  logic [9:0]  pc_addr;
  logic        branch;
  logic        pc_stall;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [9:0]  id_pc;
  logic        id_ready;
  logic [9:0]  br_addr;

  int n_vec = 0;
  int n_err = 0;
  fetch_entry_t sb[$];

  fetch_prefetch_queue #(
    .ADDR_W  (10),
    .INSTR_W (16),
    .DEPTH   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_addr    (pc_addr),
    .branch     (branch),
    .pc_stall   (pc_stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_ready   (id_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [9:0] a);
    return 16'h5A3C ^ {a[7:0], ~a[7:0]};
  endfunction

  function automatic fetch_entry_t exp_e(input int pc);
    fetch_entry_t e;
    e.pc    = 10'(pc);
    e.instr = mem_word(10'(pc));
    return e;
  endfunction

  // Program counter and instruction memory as seen by the fetch stage.
  always @(posedge clk) begin
    if (reset)          pc_addr <= '0;
    else if (branch)    pc_addr <= br_addr;
    else if (!pc_stall) pc_addr <= pc_addr + 10'd1;
  end

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
    else          imem_rdata <= 16'hDEAD;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    fetch_entry_t e;
    if (!reset && id_valid && id_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mon_unexpected: got pc %0h, expected no transfer at %0t", id_pc, $time);
      end else begin
        e = sb.pop_front();
        check("mon_pc", 32'(id_pc), 32'(e.pc));
        check("mon_instr", 32'(id_instr), 32'(e.instr));
      end
    end
  end

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b1; branch = 1'b0; br_addr = '0; id_ready = rdy;
    for (int i = 0; i < 2; i++) begin
      mid();
      check("rst_stall", 32'(pc_stall), 32'd1);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(id_valid), 32'd0);
      check("rst_id_pc", 32'(id_pc), 32'd0);
      check("rst_id_instr", 32'(id_instr), 32'd0);
      nxt();
    end
    sb.delete();
    reset = 1'b0;
  endtask

  task automatic end_test(input string name);
    id_ready = 1'b0;
    mid();
    check(name, 32'(sb.size()), 32'd0);
    nxt();
  endtask

  initial begin
    int reqs;
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqs;
    reset = 1'b1; branch = 1'b0; br_addr = '0; id_ready = 1'b0;

    // 1: streaming after reset, one instruction per cycle
    do_reset(1'b1);
    for (int k = 0; k <= 9 - LAT; k++) sb.push_back(exp_e(k));
    for (int c = 0; c < 10; c++) begin
      mid();
      if (c < LAT)  check("t1_idle", 32'(id_valid), 32'd0);
      if (c == LAT) check("t1_first_valid", 32'(id_valid), 32'd1);
      if (c < 4) begin
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr", 32'(imem_addr), 32'(c));
      end
      nxt();
    end
    end_test("t1_drained");

    // 2: back-pressure fills exactly DEPTH, then drains in order and resumes at 4
    do_reset(1'b0);
    reqs = 0;
    for (int c = 0; c < 8; c++) begin
      mid();
      if (imem_req) begin
        check("t2_addr", 32'(imem_addr), 32'(reqs));
        reqs++;
      end
      if (c == 7) begin
        check("t2_stall", 32'(pc_stall), 32'd1);
        check("t2_head_pc", 32'(id_pc), 32'd0);
      end
      nxt();
    end
    check("t2_req_count", 32'(reqs), 32'd4);
    for (int k = 0; k < 8; k++) sb.push_back(exp_e(k));
    id_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      mid();
      if (c == 0) begin
        check("t2_resume_req", 32'(imem_req), 32'd1);
        check("t2_resume_addr", 32'(imem_addr), 32'd4);
      end
      nxt();
    end
    end_test("t2_drained");

    // 3: branch to 3 flushes queue and drops the in-flight response
    do_reset(1'b0);
    sb.push_back(exp_e(0));
    sb.push_back(exp_e(1));
    for (int k = 3; k <= 8 - LAT; k++) sb.push_back(exp_e(k));
    for (int c = 0; c < 15; c++) begin
      id_ready = (c == 6 || c == 7 || c >= 9);
      branch   = (c == 8);
      br_addr  = 10'd3;
      mid();
      if (c == 8) check("t3_no_req_on_branch", 32'(imem_req), 32'd0);
      if (c == 9) begin
        check("t3_flushed", 32'(id_valid), 32'd0);
        check("t3_target_addr", 32'(imem_addr), 32'd3);
      end
      if (c == 8 + LAT) check("t3_target_not_yet", 32'(id_valid), 32'd0);
      if (c == 9 + LAT) begin
        check("t3_target_valid", 32'(id_valid), 32'd1);
        check("t3_target_pc", 32'(id_pc), 32'd3);
      end
      nxt();
    end
    branch = 1'b0;
    end_test("t3_drained");

    // 4: full queue, single-cycle pop allows exactly one new issue
    do_reset(1'b0);
    for (int k = 0; k <= 6; k++) sb.push_back(exp_e(k));
    for (int c = 0; c < 15; c++) begin
      id_ready = (c == 6 || c >= 9);
      mid();
      if (c == 5) check("t4_full_stall", 32'(pc_stall), 32'd1);
      if (c == 6) begin
        check("t4_swap_req", 32'(imem_req), 32'd1);
        check("t4_swap_addr", 32'(imem_addr), 32'd4);
      end
      if (c == 7 || c == 8) check("t4_still_full", 32'(pc_stall), 32'd1);
      if (c == 8) check("t4_head_pc", 32'(id_pc), 32'd1);
      nxt();
    end
    end_test("t4_drained");

    // 5: reset with 3 entries plus in-flight request, restart at PC 0
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) begin
      mid();
      nxt();
    end
    reset = 1'b1;
    mid();
    check("t5_rst_valid", 32'(id_valid), 32'd0);
    check("t5_rst_req", 32'(imem_req), 32'd0);
    check("t5_rst_stall", 32'(pc_stall), 32'd1);
    nxt();
    reset = 1'b0;
    id_ready = 1'b1;
    for (int k = 0; k <= 6 - LAT; k++) sb.push_back(exp_e(k));
    for (int c = 5; c < 12; c++) begin
      mid();
      if (c == 5) begin
        check("t5_after_valid", 32'(id_valid), 32'd0);
        check("t5_restart_req", 32'(imem_req), 32'd1);
        check("t5_restart_addr", 32'(imem_addr), 32'd0);
      end
      nxt();
    end
    end_test("t5_drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
